// File: rtl/stim_pkg.sv
// Shared definitions for the stimulus sequencer: FSM state encoding and the
// bit layout of one stimulus table entry ({hold, value}).
package stim_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RST  = 3'd1,
    S_RUN  = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam int VAL_LSB = 0;

  // The hold field sits directly above the pattern value.
  function automatic int hold_lsb(input int width);
    return width;
  endfunction

endpackage

// File: rtl/stim_seq_if.sv
// Control, table-load and stimulus signals of the stimulus sequencer.
// The master side (bench or board logic) drives start and the write port.
interface stim_seq_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int HW    = 16
);
  localparam int AW = $clog2(DEPTH);

  logic             start;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_value;
  logic [HW-1:0]    wr_hold;
  logic             cpu_reset;
  logic [WIDTH-1:0] porti;
  logic             busy;
  logic             done;
  logic [AW-1:0]    step;
  logic [31:0]      cycle_cnt;

  modport master (
    output start, wr_en, wr_addr, wr_value, wr_hold,
    input  cpu_reset, porti, busy, done, step, cycle_cnt
  );

  modport slave (
    input  start, wr_en, wr_addr, wr_value, wr_hold,
    output cpu_reset, porti, busy, done, step, cycle_cnt
  );
endinterface

// File: rtl/stim_table.sv
// Stimulus table: DEPTH entries of {hold, value}, one synchronous write port
// and one asynchronous read port. Contents are deliberately not reset.
module stim_table
  import stim_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int HW    = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wvalue,
  input  logic [HW-1:0]    whold,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rvalue,
  output logic [HW-1:0]    rhold
);
  localparam int HOLD_LSB = hold_lsb(WIDTH);

  logic [WIDTH+HW-1:0] mem [DEPTH];

  // Table write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= {whold, wvalue};
    end
  end

  assign rvalue = mem[raddr][VAL_LSB +: WIDTH];
  assign rhold  = mem[raddr][HOLD_LSB +: HW];
endmodule

// File: rtl/stim_seq.sv
// Stimulus sequencer: pulses cpu_reset, then plays the timed porti table and
// stops at a run-cycle limit. Define STIM_LOOP_EN to repeat the table until the limit.
module stim_seq
  import stim_pkg::*;
#(
  parameter int          WIDTH      = 32,
  parameter int          DEPTH      = 8,
  parameter int          HW         = 16,
  parameter int          RST_CYCLES = 5,
  parameter logic [31:0] MAX_CYCLES = 32'd8014
) (
  input logic       clk,
  input logic       reset,
  stim_seq_if.slave bus
);
  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [31:0]   RST_LAST = 32'(RST_CYCLES - 1);
  localparam logic [31:0]   CNT_LAST = MAX_CYCLES - 32'd1;

  state_t           state;
  logic [31:0]      rst_cnt;
  logic [HW-1:0]    rem;
  logic [AW-1:0]    rd_addr;
  logic [AW-1:0]    nxt_idx;
  logic [WIDTH-1:0] tbl_value;
  logic [HW-1:0]    tbl_hold;
  logic             tbl_we;
  logic             limit_hit;
  logic             at_last;
`ifdef STIM_LOOP_EN
  // Entry 0 is cached at run start so a wrap needs no second read port.
  logic [WIDTH-1:0] e0_value;
  logic [HW-1:0]    e0_hold;
`endif

  stim_table #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .HW    (HW)
  ) u_table (
    .clk    (clk),
    .we     (tbl_we),
    .waddr  (bus.wr_addr),
    .wvalue (bus.wr_value),
    .whold  (bus.wr_hold),
    .raddr  (rd_addr),
    .rvalue (tbl_value),
    .rhold  (tbl_hold)
  );

  // Table addressing, write gating and end-of-entry/limit decodes
  always_comb begin
    nxt_idx   = bus.step + AW'(1);
    at_last   = (bus.step == LAST_IDX);
    limit_hit = (bus.cycle_cnt == CNT_LAST);
    tbl_we    = bus.wr_en && ((state == S_IDLE) || (state == S_DONE));
    if (state == S_RUN) begin
      rd_addr = nxt_idx;
    end else begin
      rd_addr = '0;
    end
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= S_IDLE;
      rst_cnt       <= 32'd0;
      rem           <= '0;
      bus.cpu_reset <= 1'b0;
      bus.porti     <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.step      <= '0;
      bus.cycle_cnt <= 32'd0;
`ifdef STIM_LOOP_EN
      e0_value      <= '0;
      e0_hold       <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state         <= S_RST;
            rst_cnt       <= 32'd0;
            bus.cpu_reset <= 1'b1;
            bus.porti     <= '0;
            bus.busy      <= 1'b1;
            bus.done      <= 1'b0;
            bus.step      <= '0;
            bus.cycle_cnt <= 32'd0;
          end
        end
        S_RST: begin
          if (rst_cnt == RST_LAST) begin
            bus.cpu_reset <= 1'b0;
            bus.cycle_cnt <= 32'd0;
            bus.step      <= '0;
`ifdef STIM_LOOP_EN
            e0_value      <= tbl_value;
            e0_hold       <= tbl_hold;
`endif
            if (tbl_hold == '0) begin
              state     <= S_WAIT;
              bus.porti <= '0;
            end else begin
              state     <= S_RUN;
              bus.porti <= tbl_value;
              rem       <= tbl_hold - HW'(1);
            end
          end else begin
            rst_cnt <= rst_cnt + 32'd1;
          end
        end
        S_RUN: begin
          if (limit_hit) begin
            state     <= S_DONE;
            bus.porti <= '0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b1;
          end else begin
            bus.cycle_cnt <= bus.cycle_cnt + 32'd1;
            if (rem != '0) begin
              rem <= rem - HW'(1);
            end else if (at_last || (tbl_hold == '0)) begin
`ifdef STIM_LOOP_EN
              if (e0_hold == '0) begin
                state     <= S_WAIT;
                bus.porti <= '0;
              end else begin
                bus.step  <= '0;
                bus.porti <= e0_value;
                rem       <= e0_hold - HW'(1);
              end
`else
              state     <= S_WAIT;
              bus.porti <= '0;
`endif
            end else begin
              bus.step  <= nxt_idx;
              bus.porti <= tbl_value;
              rem       <= tbl_hold - HW'(1);
            end
          end
        end
        S_WAIT: begin
          if (limit_hit) begin
            state    <= S_DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end else begin
            bus.cycle_cnt <= bus.cycle_cnt + 32'd1;
          end
        end
        default: begin
          state         <= S_IDLE;
          bus.cpu_reset <= 1'b0;
          bus.porti     <= '0;
          bus.busy      <= 1'b0;
          bus.done      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_stim_seq.sv
// Self-checking bench for stim_seq: randomized tables checked against a
// cumulative-hold timeline model of the expected porti/step sequence.
module tb_stim_seq;
  localparam int          WIDTH      = 32;
  localparam int          DEPTH      = 8;
  localparam int          HW         = 16;
  localparam int          RST_CYCLES = 5;
  localparam int          MAXC       = 200;

  logic clk;
  logic reset;
  int   vectors;
  int   errors;

  logic [WIDTH-1:0] m_val  [DEPTH];
  logic [HW-1:0]    m_hold [DEPTH];

  stim_seq_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .HW(HW)) bus_if ();

  stim_seq #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .HW         (HW),
    .RST_CYCLES (RST_CYCLES),
    .MAX_CYCLES (32'(MAXC))
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Index of the entry applied in run cycle c, or -1 when porti must be 0.
  function automatic int exp_idx(input int c);
    int period;
    int n;
    int t;
    int cc;
    period = 0;
    n      = 0;
    while (n < DEPTH && m_hold[n] != 16'd0) begin
      period += int'(m_hold[n]);
      n++;
    end
    if (period == 0) return -1;
`ifdef STIM_LOOP_EN
    cc = c % period;
`else
    if (c >= period) return -1;
    cc = c;
`endif
    t = 0;
    for (int k = 0; k < n; k++) begin
      if (cc < t + int'(m_hold[k])) return k;
      t += int'(m_hold[k]);
    end
    return -1;
  endfunction

  task automatic write_entry(input int a, input logic [WIDTH-1:0] v, input logic [HW-1:0] h);
    @(negedge clk);
    bus_if.wr_en    = 1'b1;
    bus_if.wr_addr  = 3'(a);
    bus_if.wr_value = v;
    bus_if.wr_hold  = h;
    m_val[a]        = v;
    m_hold[a]       = h;
    @(negedge clk);
    bus_if.wr_en    = 1'b0;
  endtask

  // Starts a run and checks it cycle by cycle up to stop_at run cycles
  // (to DONE when stop_at >= MAXC). Optionally writes entry wa with start,
  // and pulses wr_en+start (which must be ignored) at run cycle inject_at.
  task automatic run_seq(input string name, input int stop_at, input int inject_at,
                         input bit wr_with_start, input int wa,
                         input logic [WIDTH-1:0] wv, input logic [HW-1:0] wh);
    int idx;
    logic [WIDTH-1:0] ev;
    @(negedge clk);
    bus_if.start = 1'b1;
    if (wr_with_start) begin
      bus_if.wr_en    = 1'b1;
      bus_if.wr_addr  = 3'(wa);
      bus_if.wr_value = wv;
      bus_if.wr_hold  = wh;
      m_val[wa]       = wv;
      m_hold[wa]      = wh;
    end
    @(negedge clk);
    bus_if.start = 1'b0;
    bus_if.wr_en = 1'b0;
    for (int i = 0; i < RST_CYCLES; i++) begin
      vectors++;
      if (bus_if.cpu_reset !== 1'b1 || bus_if.busy !== 1'b1 || bus_if.done !== 1'b0 ||
          bus_if.porti !== 32'd0) begin
        errors++;
        $display("FAIL %s rst_phase i=%0d got cpu_reset=%b busy=%b done=%b porti=%h, want 1 1 0 0",
                 name, i, bus_if.cpu_reset, bus_if.busy, bus_if.done, bus_if.porti);
      end
      @(negedge clk);
    end
    for (int c = 0; c < MAXC && c < stop_at; c++) begin
      idx = exp_idx(c);
      ev  = (idx < 0) ? 32'd0 : m_val[idx];
      vectors++;
      if (bus_if.porti !== ev) begin
        errors++;
        $display("FAIL %s porti c=%0d got %h want %h", name, c, bus_if.porti, ev);
      end
      vectors++;
      if (bus_if.cycle_cnt !== 32'(c) || bus_if.busy !== 1'b1 || bus_if.done !== 1'b0 ||
          bus_if.cpu_reset !== 1'b0) begin
        errors++;
        $display("FAIL %s run_status c=%0d got cnt=%0d busy=%b done=%b cpu_reset=%b, want cnt=%0d 1 0 0",
                 name, c, bus_if.cycle_cnt, bus_if.busy, bus_if.done, bus_if.cpu_reset, c);
      end
      if (idx >= 0) begin
        vectors++;
        if (bus_if.step !== 3'(idx)) begin
          errors++;
          $display("FAIL %s step c=%0d got %0d want %0d", name, c, bus_if.step, idx);
        end
      end
      if (c == inject_at) begin
        bus_if.start    = 1'b1;
        bus_if.wr_en    = 1'b1;
        bus_if.wr_addr  = 3'($urandom_range(0, DEPTH - 1));
        bus_if.wr_value = $urandom;
        bus_if.wr_hold  = 16'($urandom_range(0, 9));
      end
      @(negedge clk);
      bus_if.start = 1'b0;
      bus_if.wr_en = 1'b0;
    end
    if (stop_at >= MAXC) begin
      idx = exp_idx(MAXC - 1);
      for (int j = 0; j < 2; j++) begin
        vectors++;
        if (bus_if.done !== 1'b1 || bus_if.busy !== 1'b0 || bus_if.porti !== 32'd0 ||
            bus_if.cycle_cnt !== 32'(MAXC - 1) || bus_if.cpu_reset !== 1'b0) begin
          errors++;
          $display("FAIL %s done_state j=%0d got done=%b busy=%b porti=%h cnt=%0d cpu_reset=%b, want 1 0 0 %0d 0",
                   name, j, bus_if.done, bus_if.busy, bus_if.porti, bus_if.cycle_cnt,
                   bus_if.cpu_reset, MAXC - 1);
        end
        if (idx >= 0) begin
          vectors++;
          if (bus_if.step !== 3'(idx)) begin
            errors++;
            $display("FAIL %s done_step got %0d want %0d", name, bus_if.step, idx);
          end
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic check_idle(input string name);
    vectors++;
    if (bus_if.cpu_reset !== 1'b0 || bus_if.porti !== 32'd0 || bus_if.busy !== 1'b0 ||
        bus_if.done !== 1'b0 || bus_if.step !== 3'd0 || bus_if.cycle_cnt !== 32'd0) begin
      errors++;
      $display("FAIL %s idle got cpu_reset=%b porti=%h busy=%b done=%b step=%0d cnt=%0d, want all 0",
               name, bus_if.cpu_reset, bus_if.porti, bus_if.busy, bus_if.done,
               bus_if.step, bus_if.cycle_cnt);
    end
  endtask

  task automatic load_test1();
    write_entry(0, 32'd4, 16'd50);
    write_entry(1, 32'd0, 16'd50);
    write_entry(2, 32'd4, 16'd50);
    write_entry(3, 32'd0, 16'd0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset_low");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("reset_release");
  endtask

  task automatic test_basic_table();
    for (int k = 0; k < DEPTH; k++) write_entry(k, $urandom, 16'($urandom_range(1, 20)));
    load_test1();
    run_seq("basic", MAXC, -1, 1'b0, 0, 32'd0, 16'd0);
  endtask

  task automatic test_reset_mid_run();
    run_seq("mid_run", 30, -1, 1'b0, 0, 32'd0, 16'd0);
    reset = 1'b0;
    @(negedge clk);
    check_idle("mid_run_reset");
    reset = 1'b1;
    @(negedge clk);
    run_seq("after_reset", MAXC, -1, 1'b0, 0, 32'd0, 16'd0);
  endtask

  task automatic test_entry0_term();
    write_entry(0, 32'hDEAD_BEEF, 16'd0);
    write_entry(1, 32'h1234_5678, 16'd20);
    run_seq("entry0_term", MAXC, -1, 1'b0, 0, 32'd0, 16'd0);
  endtask

  task automatic test_full_table();
    for (int k = 0; k < DEPTH; k++) write_entry(k, 32'(k + 1), 16'd3);
    run_seq("full_table", MAXC, -1, 1'b0, 0, 32'd0, 16'd0);
  endtask

  task automatic test_busy_ignore();
    load_test1();
    run_seq("busy_ignore", MAXC, 5, 1'b0, 0, 32'd0, 16'd0);
    run_seq("busy_rerun", MAXC, 120, 1'b0, 0, 32'd0, 16'd0);
  endtask

  task automatic test_limit_override();
    write_entry(0, 32'h5A5A_5A5A, 16'd300);
    write_entry(1, 32'h0000_0011, 16'd4);
    run_seq("limit", MAXC, -1, 1'b0, 0, 32'd0, 16'd0);
  endtask

  task automatic test_back_to_back();
    int n;
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, DEPTH);
      for (int k = 0; k < DEPTH; k++) begin
        write_entry(k, $urandom, (k == n) ? 16'd0 : 16'($urandom_range(1, 40)));
      end
      run_seq("random", MAXC, -1, 1'b1, $urandom_range(0, DEPTH - 1), $urandom,
              16'($urandom_range(1, 30)));
    end
  endtask

  initial begin
    vectors         = 0;
    errors          = 0;
    reset           = 1'b0;
    bus_if.start    = 1'b0;
    bus_if.wr_en    = 1'b0;
    bus_if.wr_addr  = 3'd0;
    bus_if.wr_value = 32'd0;
    bus_if.wr_hold  = 16'd0;
    test_reset();
    test_basic_table();
    test_reset_mid_run();
    test_entry0_term();
    test_full_table();
    test_busy_ignore();
    test_limit_override();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
